edge_pattern_generator: RTL

- Transmit-side counterpart of the edge detector. It turns a queue of programmed intervals into a single-bit waveform on `signal_out`. Each queued interval produces exactly one transition, either rising or falling.
- Sits in front of `both_edge_detector` in loopback benches, and drives pattern stimulus for edge-sensitive logic on the FPGA.
- Contains a small input FIFO with valid/ready handshake, an interval down-counter and a 2-state FSM.

---
 rtl/edge_pattern_generator_if.sv | 11 +
 rtl/edge_pattern_generator.sv | 118 +++++++++++
 2 files changed

// File: rtl/edge_pattern_generator_if.sv
// Valid/ready push interface carrying programmed intervals into the edge pattern generator.
interface edge_pattern_generator_if #(
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [CNT_W-1:0] in_interval;

   modport master (output in_valid, output in_interval, input in_ready);
   modport slave  (input in_valid, input in_interval, output in_ready);
endinterface

// File: rtl/edge_pattern_generator.sv
// Turns a FIFO of intervals into a single-bit waveform: each popped interval ends in one toggle.
module edge_pattern_generator #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic        INIT_LEVEL = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   edge_pattern_generator_if.slave bus,
   input  logic                   abort,
   output logic                   signal_out,
   output logic                   edge_strobe,
   output logic                   busy
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             fifo_empty, fifo_full;
   logic             push, pop, toggle;
   logic [CNT_W-1:0] head, load;

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == (AW + 1)'(FIFO_DEPTH));
   assign bus.in_ready = !fifo_full && !rst;
   assign push        = bus.in_valid && bus.in_ready && !abort;

   // Interval 0 behaves like 1, so both load a zero count.
   assign head = mem_q[rd_ptr_q];
   assign load = (head == '0) ? '0 : head - CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      toggle  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cnt_d   = load;
               state_d = StRun;
            end
         end
         StRun: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               toggle = 1'b1;
               if (!fifo_empty) begin
                  pop   = 1'b1;
                  cnt_d = load;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Abort wins over both the pending toggle and any pop.
      if (abort) begin
         pop     = 1'b0;
         toggle  = 1'b0;
         cnt_d   = '0;
         state_d = StIdle;
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
      if (abort) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         signal_out  <= INIT_LEVEL;
         edge_strobe <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         count_q     <= count_d;
         signal_out  <= signal_out ^ toggle;
         edge_strobe <= toggle;
         busy        <= (state_d == StRun) || (count_d != '0);
         if (abort) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.in_interval;
      end
   end
endmodule
